// File: rtl/fma_share_arbiter_if.sv
// Purpose : request/response/FMA-side signal bundle for fma_share_arbiter.
// Latency : none (wires only).
// Backpr. : valid/ready per requester on both request and response sides.
// Ports   : req_valid/ready, req_a/b/c/op/rm (packed per requester),
//           rsp_valid/ready, rsp_out/flags, fpu_a/b/c/op/rm, fpu_out/flags.
interface fma_share_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int RECLEN = 33
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*RECLEN-1:0] req_a;
  logic [N_REQ*RECLEN-1:0] req_b;
  logic [N_REQ*RECLEN-1:0] req_c;
  logic [N_REQ*3-1:0]      req_op;
  logic [N_REQ*3-1:0]      req_rm;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [RECLEN-1:0]       rsp_out;
  logic [4:0]              rsp_flags;
  logic [RECLEN-1:0]       fpu_a;
  logic [RECLEN-1:0]       fpu_b;
  logic [RECLEN-1:0]       fpu_c;
  logic [2:0]              fpu_op;
  logic [2:0]              fpu_rm;
  logic [RECLEN-1:0]       fpu_out;
  logic [4:0]              fpu_flags;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_c, req_op, req_rm, rsp_ready,
    input  fpu_out, fpu_flags,
    output req_ready, rsp_valid, rsp_out, rsp_flags,
    output fpu_a, fpu_b, fpu_c, fpu_op, fpu_rm
  );

  // Requesters plus the FMA datapath.
  modport master (
    output req_valid, req_a, req_b, req_c, req_op, req_rm, rsp_ready,
    output fpu_out, fpu_flags,
    input  req_ready, rsp_valid, rsp_out, rsp_flags,
    input  fpu_a, fpu_b, fpu_c, fpu_op, fpu_rm
  );
endinterface

// File: rtl/fma_share_arbiter.sv
// Purpose : round-robin sharing of one combinational FMA among N_REQ requesters.
// Latency : request handshake in cycle T -> rsp_valid in cycle T+FPU_LAT+1.
// Backpr. : one op in flight; req_ready only in IDLE, result held until owner accepts.
// Ports   : clk_i, rst_i (sync, active high), bus (slave modport: requests,
//           responses, registered FMA operands, FMA result), busy_o (not IDLE).
module fma_share_arbiter #(
  parameter int N_REQ   = 2,
  parameter int EXPW    = 8,
  parameter int SIGW    = 24,
  parameter int RECLEN  = EXPW + SIGW + 1,
  parameter int FPU_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fma_share_arbiter_if.slave bus,
  output logic               busy_o
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(FPU_LAT + 1);

  if (FPU_LAT < 1) begin : g_bad_lat
    $error("fma_share_arbiter: FPU_LAT must be >= 1");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("fma_share_arbiter: N_REQ must be 2..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     owner_q, owner_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [RECLEN-1:0] fpu_a_q, fpu_a_d;
  logic [RECLEN-1:0] fpu_b_q, fpu_b_d;
  logic [RECLEN-1:0] fpu_c_q, fpu_c_d;
  logic [2:0]        fpu_op_q, fpu_op_d;
  logic [2:0]        fpu_rm_q, fpu_rm_d;
  logic [RECLEN-1:0] rsp_out_q, rsp_out_d;
  logic [4:0]        rsp_flags_q, rsp_flags_d;

  logic              grant_vld;
  logic [GW-1:0]     grant_idx;
  logic [GW:0]       rr_sum;

  // Round-robin pick: scan last_grant+1, +2, ... with wrap; the first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_grant_q} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(N_REQ)) begin
        rr_sum = rr_sum - (GW+1)'(N_REQ);
      end
      if (!grant_vld && bus.req_valid[rr_sum[GW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    fpu_a_d       = fpu_a_q;
    fpu_b_d       = fpu_b_q;
    fpu_c_d       = fpu_c_q;
    fpu_op_d      = fpu_op_q;
    fpu_rm_d      = fpu_rm_q;
    rsp_out_d     = rsp_out_q;
    rsp_flags_d   = rsp_flags_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          // Outputs are forced low while reset is asserted so no handshake is seen.
          bus.req_ready[grant_idx] = !rst_i;
          fpu_a_d  = bus.req_a[int'(grant_idx)*RECLEN +: RECLEN];
          fpu_b_d  = bus.req_b[int'(grant_idx)*RECLEN +: RECLEN];
          fpu_c_d  = bus.req_c[int'(grant_idx)*RECLEN +: RECLEN];
          fpu_op_d = bus.req_op[int'(grant_idx)*3 +: 3];
          fpu_rm_d = bus.req_rm[int'(grant_idx)*3 +: 3];
          owner_d  = grant_idx;
          cnt_d    = CW'(FPU_LAT);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        // Last settle cycle: the FMA output now reflects the registered operands.
        if (cnt_q == CW'(1)) begin
          rsp_out_d   = bus.fpu_out;
          rsp_flags_d = bus.fpu_flags;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        bus.rsp_valid[owner_q] = !rst_i;
        if (bus.rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_c_q      <= '0;
      fpu_op_q     <= '0;
      fpu_rm_q     <= '0;
      rsp_out_q    <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_c_q      <= fpu_c_d;
      fpu_op_q     <= fpu_op_d;
      fpu_rm_q     <= fpu_rm_d;
      rsp_out_q    <= rsp_out_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign bus.fpu_a     = fpu_a_q;
  assign bus.fpu_b     = fpu_b_q;
  assign bus.fpu_c     = fpu_c_q;
  assign bus.fpu_op    = fpu_op_q;
  assign bus.fpu_rm    = fpu_rm_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fma_share_arbiter.sv
// Purpose : self-checking bench for fma_share_arbiter with a stand-in FMA.
// Latency : checks handshake -> rsp_valid at T+FPU_LAT+1.
// Backpr. : exercises held responses, round-robin contention and mid-op reset.
module tb_fma_share_arbiter;
  localparam int N_REQ   = 2;
  localparam int RECLEN  = 33;
  localparam int FPU_LAT = 2;

  // Recoded single-precision constants (exponent field = biased exp + 129).
  localparam logic [32:0] R_ONE  = 33'h0_8000_0000;
  localparam logic [32:0] R_TWO  = 33'h0_8080_0000;
  localparam logic [32:0] R_HALF = 33'h0_7F80_0000;
  localparam logic [32:0] R_2P5  = 33'h0_80A0_0000;
  localparam logic [32:0] R_MAX  = 33'h0_BFFF_FFFF;
  localparam logic [32:0] R_ZERO = 33'h0_0000_0000;
  localparam logic [32:0] R_PINF = 33'h0_C000_0000;
  localparam logic [32:0] R_QNAN = 33'h0_E040_0000;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  fma_share_arbiter_if #(.N_REQ(N_REQ), .RECLEN(RECLEN)) bus ();

  fma_share_arbiter #(.N_REQ(N_REQ), .EXPW(8), .SIGW(24), .FPU_LAT(FPU_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave),
    .busy_o(busy)
  );

  // Stand-in FMA: exact results for the IEEE corner cases, an operand hash otherwise.
  function automatic logic [37:0] fma_stub(input logic [32:0] a, b, c, input logic [2:0] op, rm);
    logic [32:0] h;
    if (a == R_ONE && b == R_TWO && c == R_HALF && op == 3'd0) return {5'b00000, R_2P5};
    if (a == R_MAX && b == R_MAX && c == R_ZERO && op == 3'd0) return {5'b00101, R_PINF};
    if ((a == R_ZERO && b == R_PINF) || (a == R_PINF && b == R_ZERO)) return {5'b10000, R_QNAN};
    h = (a ^ {b[16:0], b[32:17]}) + c + {27'd0, op, rm};
    return {h[4:0] ^ a[9:5] ^ b[14:10], h};
  endfunction

  always_comb {bus.fpu_flags, bus.fpu_out} = fma_stub(bus.fpu_a, bus.fpu_b, bus.fpu_c, bus.fpu_op, bus.fpu_rm);

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int          owner;
    logic [32:0] out;
    logic [4:0]  flags;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   hs_owner[$];
  int   hs_cyc[$];
  int   lg_m;
  int   mg;
  bit   rsp_seen;
  bit   acc;
  logic [N_REQ-1:0] hold_vld;
  logic [32:0]      hold_out;
  logic [4:0]       hold_flags;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      rsp_seen = 1'b0;
      lg_m     = N_REQ - 1;
    end else begin
      chk("ready_valid_excl", {63'd0, (|bus.req_ready) && (|bus.rsp_valid)}, 64'd0);
      chk("req_ready_onehot0", {63'd0, $onehot0(bus.req_ready)}, 64'd1);
      chk("rsp_valid_onehot0", {63'd0, $onehot0(bus.rsp_valid)}, 64'd1);
      if (|(bus.req_valid & bus.req_ready)) begin
        mg = rr_pick(lg_m, bus.req_valid);
        if (mg < 0) mg = 0;
        chk("grant", bus.req_ready, 64'd1 << mg);
        me.owner = mg;
        {me.flags, me.out} = fma_stub(bus.req_a[mg*RECLEN +: RECLEN], bus.req_b[mg*RECLEN +: RECLEN],
                                      bus.req_c[mg*RECLEN +: RECLEN], bus.req_op[mg*3 +: 3],
                                      bus.req_rm[mg*3 +: 3]);
        me.due = cyc + FPU_LAT + 1;
        sb.push_back(me);
        hs_owner.push_back(mg);
        hs_cyc.push_back(cyc);
      end
      if (rsp_seen) begin
        chk("rsp_hold_valid", bus.rsp_valid, hold_vld);
        chk("rsp_hold_out", bus.rsp_out, hold_out);
        chk("rsp_hold_flags", bus.rsp_flags, hold_flags);
      end else if (|bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding (cycle %0d)", bus.rsp_valid, cyc);
        end else begin
          me = sb.pop_front();
          chk("rsp_owner", bus.rsp_valid, 64'd1 << me.owner);
          chk("rsp_out", bus.rsp_out, me.out);
          chk("rsp_flags", bus.rsp_flags, me.flags);
          chk("rsp_latency", cyc, me.due);
        end
        hold_vld   = bus.rsp_valid;
        hold_out   = bus.rsp_out;
        hold_flags = bus.rsp_flags;
      end
      acc = |(bus.rsp_valid & bus.rsp_ready);
      if (acc) begin
        for (int i = 0; i < N_REQ; i++) if (bus.rsp_valid[i]) lg_m = i;
      end
      rsp_seen = (|bus.rsp_valid) && !acc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input int r, input logic [32:0] a, b, c, input logic [2:0] op, rm);
    bus.req_a[r*RECLEN +: RECLEN] = a;
    bus.req_b[r*RECLEN +: RECLEN] = b;
    bus.req_c[r*RECLEN +: RECLEN] = c;
    bus.req_op[r*3 +: 3]          = op;
    bus.req_rm[r*3 +: 3]          = rm;
  endtask

  task automatic wait_hs(input int r, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.req_valid[r] && bus.req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int r, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.rsp_valid[r]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          req;
    logic [32:0] a, b, c;
    logic [2:0]  op, rm;
    logic [32:0] e_out;
    logic [4:0]  e_flags;
  } vec_t;

  vec_t vecs[6];

  task automatic fill(input int i, input int r, input logic [32:0] a, b, c, input logic [2:0] op, rm,
                      input logic [32:0] eo, input logic [4:0] ef);
    vecs[i].req = r; vecs[i].a = a; vecs[i].b = b; vecs[i].c = c;
    vecs[i].op = op; vecs[i].rm = rm; vecs[i].e_out = eo; vecs[i].e_flags = ef;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  bit          ok;
  int          base;
  int          t;
  logic [37:0] st;
  logic [32:0] op1_a;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_op    = '0;
    bus.req_rm    = '0;

    fill(0, 0, R_ONE,  R_TWO,  R_HALF, 3'd0, 3'd0, R_2P5,  5'b00000);
    fill(1, 1, R_MAX,  R_MAX,  R_ZERO, 3'd0, 3'd0, R_PINF, 5'b00101);
    fill(2, 0, R_ZERO, R_PINF, R_ONE,  3'd0, 3'd0, R_QNAN, 5'b10000);
    st = fma_stub(33'h0_1234_5678, 33'h1_0ABC_DEF0, 33'h0_0F0F_0F0F, 3'd1, 3'd2);
    fill(3, 1, 33'h0_1234_5678, 33'h1_0ABC_DEF0, 33'h0_0F0F_0F0F, 3'd1, 3'd2, st[32:0], st[37:33]);
    st = fma_stub(33'h1_FEDC_BA98, 33'h0_7654_3210, 33'h1_0000_0001, 3'd2, 3'd4);
    fill(4, 0, 33'h1_FEDC_BA98, 33'h0_7654_3210, 33'h1_0000_0001, 3'd2, 3'd4, st[32:0], st[37:33]);
    st = fma_stub(33'h0_5555_AAAA, 33'h1_3333_CCCC, 33'h0_8888_1111, 3'd3, 3'd1);
    fill(5, 1, 33'h0_5555_AAAA, 33'h1_3333_CCCC, 33'h0_8888_1111, 3'd3, 3'd1, st[32:0], st[37:33]);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_fpu_a", bus.fpu_a, 0);
    chk("reset_fpu_op", bus.fpu_op, 0);
    chk("reset_rsp_out", bus.rsp_out, 0);
    chk("reset_rsp_flags", bus.rsp_flags, 0);

    // Table: one requester at a time, result and flags against the table.
    @(posedge clk); #1;
    bus.rsp_ready = '1;
    foreach (vecs[i]) begin
      set_ops(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, vecs[i].rm);
      bus.req_valid = '0;
      bus.req_valid[vecs[i].req] = 1'b1;
      wait_hs(vecs[i].req, ok);
      chk("tbl_handshake", ok, 1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_rsp(vecs[i].req, ok);
      chk("tbl_rsp_seen", ok, 1);
      chk("tbl_rsp_out", bus.rsp_out, vecs[i].e_out);
      chk("tbl_rsp_flags", bus.rsp_flags, vecs[i].e_flags);
      @(posedge clk); #1;
    end
    wait_idle(ok);
    chk("tbl_drain", ok, 1);
    chk("fpu_hold_idle", bus.fpu_a, vecs[5].a);

    // Contention from reset: grants alternate 0,1,0,1 every FPU_LAT+2 cycles.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_ops(0, 33'h0_1111_2222, 33'h0_3333_4444, 33'h0_0000_5555, 3'd0, 3'd1);
    set_ops(1, 33'h1_6666_7777, 33'h0_0888_9999, 33'h1_AAAA_0000, 3'd1, 3'd0);
    op1_a = 33'h1_6666_7777;
    base = hs_owner.size();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    t = 0;
    while (hs_owner.size() < base + 4 && t < 80) begin
      @(posedge clk);
      t++;
    end
    #1 bus.req_valid = '0;
    chk("rr_count", {63'd0, hs_owner.size() >= base + 4}, 1);
    if (hs_owner.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("rr_owner", hs_owner[base+k], k % 2);
      for (int k = 1; k < 4; k++) chk("rr_interval", hs_cyc[base+k] - hs_cyc[base+k-1], FPU_LAT + 2);
    end
    wait_idle(ok);
    chk("rr_drain", ok, 1);

    // Owner 0 stalls its response; non-owner ready must be ignored, req1 must wait.
    @(posedge clk); #1;
    bus.rsp_ready = 2'b10;
    bus.req_valid = 2'b11;
    wait_hs(0, ok);
    chk("stall_hs_req0", ok, 1);
    wait_rsp(0, ok);
    chk("stall_rsp_seen", ok, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", bus.rsp_valid, 2'b01);
      chk("stall_req_ready", bus.req_ready, 2'b00);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    wait_hs(1, ok);
    chk("stall_then_req1", ok, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle(ok);
    chk("stall_drain", ok, 1);

    // Reset while an op is in EXEC: op dropped, req1 granted immediately after.
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    wait_hs(0, ok);
    chk("rst_hs_req0", ok, 1);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_low", busy, 0);
    chk("rst_grant_req1", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle(ok);
    chk("rst_drain", ok, 1);
    chk("fpu_hold_after_rst", bus.fpu_a, op1_a);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
